// File: rtl/otp_pkg.sv
// otp_pkg: shared definitions for the OTP array sequencers.
//  - Drive-level encodings for plate lines (PL), bit lines (BL),
//    NMOS/PMOS word lines (WLN/WLP) and the read/program path select (PRG).
//  - State encoding of the read sequencer.
// Shared between the read sequencer and the program FSM, so both agree on
// what each level code means at the array-level mux.
package otp_pkg;

  // Bit-line levels
  localparam logic       BL_V_GND    = 1'b0;
  localparam logic       BL_V_MID    = 1'b1;

  // Plate-line levels, 2 bits per column
  localparam logic [1:0] PL_V_GND    = 2'b00;
  localparam logic [1:0] PL_V_MID    = 2'b01;
  localparam logic [1:0] PL_V_READ   = 2'b10;
  localparam logic [1:0] PL_V_HIGH   = 2'b11;

  // NMOS word line: 0 selects the row
  localparam logic       WLN_V_MID   = 1'b0;
  localparam logic       WLN_V_GND   = 1'b1;

  // PMOS word line: the read path never drives V_HIGH
  localparam logic       WLP_V_HIGH  = 1'b0;
  localparam logic       WLP_V_MID   = 1'b1;

  // Path select
  localparam logic       PRG_READING = 1'b0;
  localparam logic       PRG_WRITING = 1'b1;

  typedef enum logic [3:0] {
    RD_IDLE,
    RD_PREP_PL,
    RD_PREP_PRG,
    RD_ROW_SEL,
    RD_ROW_SETTLE,
    RD_ROW_SAMPLE,
    RD_ROW_DESEL,
    RD_POWER_DN,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/otp_settle_timer.sv
// otp_settle_timer: down-counter used to hold a state for a fixed number
// of cycles while array voltages settle. Shared by read and program FSMs.
// Ports:
//  clk, reset  clock, synchronous active-high reset (counter -> 0)
//  load        load load_val (takes priority over count)
//  load_val    value to load
//  count       decrement by one, saturating at 0
//  done        counter is 0
module otp_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (count && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/otp_read_sequencer.sv
// otp_read_sequencer: reads one A-bit column of the OTP array.
// Biases the selected plate line for read, walks the word lines one row at
// a time, waits for the sense amp to settle, samples sense_in, and returns
// the word on data_out with a one-cycle data_valid pulse.
// Ports:
//  clk, reset   clock, synchronous active-high reset
//  start        read request (accepted only in IDLE with column < B)
//  column       column to read, latched on accepted start
//  sense_in     sense-amp output for the selected cell (1 = programmed)
//  PL/BL/WLN/WLP/PRG  array drive, muxed with the program FSM by read_active
//  read_active  sequencer owns the array
//  busy         not in IDLE
//  data_out     last read word, bit r = row r
//  data_valid   one-cycle pulse when data_out updates
//  read_error   double-sample disagreement (sticky until next start)
// Build option: define READ_DOUBLE_SAMPLE_EN to take two samples per row
// with up to two re-settle retries on disagreement; otherwise read_error
// is tied 0.
// All outputs are flops decoded from the next state, so an output belongs
// to the state it is visible in (e.g. data_valid is high during DONE).
module otp_read_sequencer
  import otp_pkg::*;
#(
  parameter int A             = 2,
  parameter int B             = 2,
  parameter int ADDR_WIDTH    = $clog2(B),
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] column,
  input  logic                  sense_in,
  output logic [2*B-1:0]        PL,
  output logic [B-1:0]          BL,
  output logic [A-1:0]          WLN,
  output logic [A-1:0]          WLP,
  output logic                  PRG,
  output logic                  read_active,
  output logic                  busy,
  output logic [A-1:0]          data_out,
  output logic                  data_valid,
  output logic                  read_error
);

  // One extra bit so row never wraps for power-of-two A
  localparam int RW = $clog2(A) + 1;
  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  rd_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] col_q, col_sel;
  logic [RW-1:0]         row, row_next;
  logic [A-1:0]          word, word_next;
  logic                  tmr_load, tmr_count, tmr_done;
  logic [2*B-1:0]        pl_next;
  logic [A-1:0]          wln_next;
  logic                  own_next;
  logic                  accept;

`ifdef READ_DOUBLE_SAMPLE_EN
  logic       phase, phase_next;    // 0: first sample, 1: compare sample
  logic       first_s, first_next;
  logic [1:0] retry, retry_next;
  logic       err_set;
`endif

  otp_settle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  assign accept  = (state == RD_IDLE) && start && (32'(column) < B);
  // The column input is only looked at in IDLE; afterwards the latch rules
  assign col_sel = (state == RD_IDLE) ? column : col_q;

  always_comb begin
    state_next = state;
    row_next   = row;
    word_next  = word;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
`ifdef READ_DOUBLE_SAMPLE_EN
    phase_next = phase;
    first_next = first_s;
    retry_next = retry;
    err_set    = 1'b0;
`endif
    case (state)
      RD_IDLE: begin
        if (accept) begin
          state_next = RD_PREP_PL;
          word_next  = '0;
        end
      end
      RD_PREP_PL:  state_next = RD_PREP_PRG;
      RD_PREP_PRG: begin
        state_next = RD_ROW_SEL;
        row_next   = '0;
      end
      RD_ROW_SEL: begin
        tmr_load   = 1'b1;
        state_next = RD_ROW_SETTLE;
`ifdef READ_DOUBLE_SAMPLE_EN
        phase_next = 1'b0;
        retry_next = '0;
`endif
      end
      RD_ROW_SETTLE: begin
        if (tmr_done) state_next = RD_ROW_SAMPLE;
        else          tmr_count  = 1'b1;
      end
      RD_ROW_SAMPLE: begin
`ifdef READ_DOUBLE_SAMPLE_EN
        if (!phase) begin
          first_next = sense_in;
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (sense_in == first_s || retry == 2'd2) begin
            for (int r = 0; r < A; r++)
              if (row == RW'(r)) word_next[r] = sense_in;
            err_set    = (sense_in != first_s);
            state_next = RD_ROW_DESEL;
          end else begin
            // Disagreement: give the cell a full settle window again
            retry_next = retry + 2'd1;
            tmr_load   = 1'b1;
            state_next = RD_ROW_SETTLE;
          end
        end
`else
        for (int r = 0; r < A; r++)
          if (row == RW'(r)) word_next[r] = sense_in;
        state_next = RD_ROW_DESEL;
`endif
      end
      RD_ROW_DESEL: begin
        if (row == RW'(A - 1)) begin
          state_next = RD_POWER_DN;
        end else begin
          row_next   = row + 1'b1;
          state_next = RD_ROW_SEL;
        end
      end
      RD_POWER_DN: state_next = RD_DONE;
      RD_DONE:     state_next = RD_IDLE;
      default:     state_next = RD_IDLE;
    endcase
  end

  // Drive levels for the state being entered
  always_comb begin
    own_next = state_next inside {RD_PREP_PL, RD_PREP_PRG, RD_ROW_SEL,
                                  RD_ROW_SETTLE, RD_ROW_SAMPLE, RD_ROW_DESEL};
    pl_next  = '0;
    wln_next = {A{WLN_V_GND}};
    if (own_next) begin
      for (int c = 0; c < B; c++)
        pl_next[2*c +: 2] = (32'(col_sel) == c) ? PL_V_READ : PL_V_GND;
    end
    // Word line stays selected through settle and sample; one row at most
    if (state_next inside {RD_ROW_SEL, RD_ROW_SETTLE, RD_ROW_SAMPLE}) begin
      for (int r = 0; r < A; r++)
        if (row_next == RW'(r)) wln_next[r] = WLN_V_MID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RD_IDLE;
      col_q       <= '0;
      row         <= '0;
      word        <= '0;
      PL          <= {B{PL_V_GND}};
      BL          <= {B{BL_V_GND}};
      WLN         <= {A{WLN_V_GND}};
      WLP         <= {A{WLP_V_MID}};
      PRG         <= PRG_READING;
      read_active <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      row         <= row_next;
      word        <= word_next;
      if (accept) col_q <= column;
      PL          <= pl_next;
      BL          <= {B{BL_V_GND}};
      WLN         <= wln_next;
      WLP         <= {A{WLP_V_MID}};
      PRG         <= PRG_READING;
      read_active <= own_next;
      busy        <= (state_next != RD_IDLE);
      data_valid  <= (state_next == RD_DONE);
      if (state_next == RD_DONE) data_out <= word_next;
    end
  end

`ifdef READ_DOUBLE_SAMPLE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 1'b0;
      first_s    <= 1'b0;
      retry      <= '0;
      read_error <= 1'b0;
    end else begin
      phase   <= phase_next;
      first_s <= first_next;
      retry   <= retry_next;
      if (accept)       read_error <= 1'b0;
      else if (err_set) read_error <= 1'b1;
    end
  end
`else
  assign read_error = 1'b0;
`endif

endmodule
